// File: rtl/bf_pkg.sv
// Shared definitions for the lamp bar-graph datapath (lamp_sequencer) and its
// controlling next_state_generator.
//   - main-state encodings (IDLE = 000 plus the run states)
//   - count command encodings driven on count_state
//   - lamp-count direction as remembered by lamp_sequencer
//   - default lamp count and kickback points
//   - sat_to(): clamp a count value to an upper limit
package bf_pkg;

  localparam int unsigned CNT_W      = 5;
  localparam int unsigned MS_W       = 3;
  localparam int unsigned LAMP_N_DEF = 16;
  localparam int unsigned KB_A_DEF   = 0;
  localparam int unsigned KB_B_DEF   = 5;

  typedef enum logic [MS_W-1:0] {
    MS_IDLE  = 3'b000,
    MS_FILL  = 3'b001,
    MS_DRAIN = 3'b010,
    MS_KICK  = 3'b011,
    MS_FULL  = 3'b100,
    MS_EMPTY = 3'b101
  } main_state_t;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_UP   = 2'b01,
    CNT_DOWN = 2'b10,
    CNT_RSVD = 2'b11
  } count_state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  function automatic logic [CNT_W-1:0] sat_to(input logic [CNT_W-1:0] value,
                                              input logic [CNT_W-1:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/lamp_sequencer_step_prescaler.sv
// step_prescaler: free-running divider that produces the count-step strobe.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   tick : registered, high for one cycle out of every STEP_DIV cycles
//          (held high permanently when STEP_DIV = 1)
// Parameter STEP_DIV (1..255): cycles per tick.
module step_prescaler #(
  parameter int unsigned STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(STEP_DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_next;

  always_comb begin
    cnt_next = (cnt_q == LAST) ? '0 : cnt_q + 8'd1;
  end

  // tick is registered from cnt_next so it equals (cnt_q == LAST) without a
  // combinational decode on the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tick  <= (STEP_DIV == 1);
    end else begin
      cnt_q <= cnt_next;
      tick  <= (cnt_next == LAST);
    end
  end

endmodule

// File: rtl/lamp_sequencer.sv
// lamp_sequencer: register bank and lamp-count datapath behind the
// bar-graph controller.
//   clk             : clock, rising edge
//   rst             : asynchronous active-high reset
//   main_state_n    : next main state from next_state_generator
//   counter_load    : value loaded into the lamp counter (saturates to LAMP_N)
//   counter_load_en : load strobe, wins over count_state
//   count_state     : HOLD / UP / DOWN / reserved, applied on step_tick
//   main_state      : registered main state
//   counter         : registered lamp count, 0..LAMP_N
//   kickback_match  : counting down and counter at KB_A or KB_B
//   lamp            : registered thermometer vector, bit i set iff i < counter
//   step_tick       : prescaler strobe
module lamp_sequencer
  import bf_pkg::*;
#(
  parameter int unsigned STEP_DIV = 1,
  parameter int unsigned LAMP_N   = LAMP_N_DEF,
  parameter int unsigned KB_A     = KB_A_DEF,
  parameter int unsigned KB_B     = KB_B_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MS_W-1:0]   main_state_n,
  input  logic [CNT_W-1:0]  counter_load,
  input  logic              counter_load_en,
  input  logic [1:0]        count_state,
  output logic [MS_W-1:0]   main_state,
  output logic [CNT_W-1:0]  counter,
  output logic              kickback_match,
  output logic [LAMP_N-1:0] lamp,
  output logic              step_tick
);

  localparam logic [CNT_W-1:0] LAMP_MAX = CNT_W'(LAMP_N);
  localparam logic [CNT_W-1:0] KB_A_V   = CNT_W'(KB_A);
  localparam logic [CNT_W-1:0] KB_B_V   = CNT_W'(KB_B);

  count_state_t       cmd;
  dir_t               dir_q;
  dir_t               dir_next;
  logic [CNT_W-1:0]   cnt_next;
  logic [LAMP_N-1:0]  lamp_next;

  assign cmd = count_state_t'(count_state);

  step_prescaler #(
    .STEP_DIV(STEP_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .tick(step_tick)
  );

  // Main state is a plain pipeline register; it is not gated by step_tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_state <= '0;
    end else begin
      main_state <= main_state_n;
    end
  end

  // Load beats counting; counting only advances on step_tick and saturates
  // at both ends.
  always_comb begin
    cnt_next = counter;
    if (counter_load_en) begin
      cnt_next = sat_to(counter_load, LAMP_MAX);
    end else if (step_tick) begin
      unique case (cmd)
        CNT_UP: begin
          if (counter < LAMP_MAX) begin
            cnt_next = counter + CNT_W'(1);
          end
        end
        CNT_DOWN: begin
          if (counter != '0) begin
            cnt_next = counter - CNT_W'(1);
          end
        end
        default: cnt_next = counter;
      endcase
    end
  end

  // Direction follows the command every cycle, independent of step_tick and
  // of a simultaneous load.
  always_comb begin
    dir_next = dir_q;
    unique case (cmd)
      CNT_UP:   dir_next = DIR_UP;
      CNT_DOWN: dir_next = DIR_DOWN;
      default:  dir_next = dir_q;
    endcase
  end

  // Lamps decode the next count so lamp and counter move on the same edge.
  always_comb begin
    lamp_next = '0;
    for (int unsigned i = 0; i < LAMP_N; i++) begin
      lamp_next[i] = (i < 32'(cnt_next));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
      lamp    <= '0;
      dir_q   <= DIR_UP;
    end else begin
      counter <= cnt_next;
      lamp    <= lamp_next;
      dir_q   <= dir_next;
    end
  end

  assign kickback_match = (dir_q == DIR_DOWN) &&
                          ((counter == KB_A_V) || (counter == KB_B_V));

endmodule

// File: tb/tb_lamp_sequencer.sv
module tb_lamp_sequencer;
  import bf_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  msn = '0;
  logic [4:0]  ld = '0;
  logic        ld_en = 1'b0;
  logic [1:0]  cs = '0;

  logic [2:0]  ms1, ms4;
  logic [4:0]  c1, c4;
  logic        kb1, kb4;
  logic [15:0] l1, l4;
  logic        tk1, tk4;

  always #5 clk = ~clk;

  lamp_sequencer #(.STEP_DIV(1)) d1 (
    .clk(clk), .rst(rst), .main_state_n(msn), .counter_load(ld),
    .counter_load_en(ld_en), .count_state(cs), .main_state(ms1),
    .counter(c1), .kickback_match(kb1), .lamp(l1), .step_tick(tk1)
  );

  lamp_sequencer #(.STEP_DIV(4)) d4 (
    .clk(clk), .rst(rst), .main_state_n(msn), .counter_load(ld),
    .counter_load_en(ld_en), .count_state(cs), .main_state(ms4),
    .counter(c4), .kickback_match(kb4), .lamp(l4), .step_tick(tk4)
  );

  // which: 0 = STEP_DIV 1 instance, 1 = STEP_DIV 4 instance, 2 = both
  // mask : bit0 counter, bit1 lamp, bit2 kickback, bit3 main_state, bit4 tick
  typedef struct {
    int         which;
    bit  [4:0]  mask;
    logic [4:0] c;
    logic [15:0] lamp;
    logic       kb;
    logic [2:0] ms;
    logic       tk1;
    logic       tk4;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  event async_ev;

  function automatic logic [15:0] thermo(input logic [4:0] c);
    logic [16:0] t;
    t = (17'd1 << c) - 17'd1;
    return t[15:0];
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_dut(input exp_t e, input string d, input logic [4:0] c,
                         input logic [15:0] l, input logic kb, input logic [2:0] ms,
                         input logic tk, input logic etk);
    if (e.mask[0]) cmp({e.tag, "/", d, "/counter"}, 32'(c), 32'(e.c));
    if (e.mask[1]) cmp({e.tag, "/", d, "/lamp"}, 32'(l), 32'(e.lamp));
    if (e.mask[2]) cmp({e.tag, "/", d, "/kickback"}, 32'(kb), 32'(e.kb));
    if (e.mask[3]) cmp({e.tag, "/", d, "/main_state"}, 32'(ms), 32'(e.ms));
    if (e.mask[4]) cmp({e.tag, "/", d, "/step_tick"}, 32'(tk), 32'(etk));
  endtask

  // Monitor: one expectation per sample point (post-edge, or async reset probe).
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or async_ev);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.which != 1) chk_dut(e, "div1", c1, l1, kb1, ms1, tk1, e.tk1);
        if (e.which != 0) chk_dut(e, "div4", c4, l4, kb4, ms4, tk4, e.tk4);
      end
    end
  end

  function automatic exp_t mk(input int w, input bit [4:0] m, input logic [4:0] c,
                              input logic kb, input logic [2:0] ms, input logic t1,
                              input logic t4, input string tag);
    exp_t e;
    e.which = w; e.mask = m; e.c = c; e.lamp = thermo(c); e.kb = kb;
    e.ms = ms; e.tk1 = t1; e.tk4 = t4; e.tag = tag;
    return e;
  endfunction

  // Drive one cycle at the falling edge; expectation is for after the next rising edge.
  task automatic cyc(input int w, input logic [4:0] l, input logic le, input logic [1:0] c,
                     input logic [2:0] m, input logic [4:0] ec, input logic ekb,
                     input logic etk, input string tag);
    ld = l; ld_en = le; cs = c; msn = m;
    q.push_back(mk(w, 5'b11111, ec, ekb, m, etk, etk, tag));
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] c;
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] ec;
    @(negedge clk);

    // Reset applied asynchronously, probed before any clock edge
    #1 rst = 1'b1;
    q.push_back(mk(2, 5'b11111, 5'd0, 1'b0, 3'd0, 1'b1, 1'b0, "reset"));
    ->async_ev;
    @(negedge clk);
    rst = 1'b0;

    // Count up from 0 with step every cycle; saturates at 16
    for (int k = 1; k <= 20; k++) begin
      ec = (k >= 16) ? 5'd16 : 5'(k);
      cyc(0, 5'd0, 1'b0, CNT_UP, 3'(k - 1), ec, 1'b0, 1'b1, "up");
    end

    // Count down from 16; kickback at 5 and 0; holds at 0
    for (int k = 1; k <= 20; k++) begin
      ec = (k >= 16) ? 5'd0 : 5'(16 - k);
      cyc(0, 5'd0, 1'b0, CNT_DOWN, 3'(k + 3), ec, (ec == 5'd5) || (ec == 5'd0), 1'b1, "down");
    end

    // Over-range load with DOWN: load only, direction DOWN, 16 is not a kickback point
    cyc(0, 5'd20, 1'b1, CNT_DOWN, 3'd1, 5'd16, 1'b0, 1'b1, "load20");
    cyc(0, 5'd0, 1'b0, CNT_HOLD, 3'd2, 5'd16, 1'b0, 1'b1, "hold");
    cyc(0, 5'd0, 1'b0, CNT_HOLD, 3'd3, 5'd16, 1'b0, 1'b1, "hold");
    for (int k = 1; k <= 11; k++) begin
      ec = 5'(16 - k);
      cyc(0, 5'd0, 1'b0, CNT_DOWN, 3'(k), ec, ec == 5'd5, 1'b1, "down2");
    end
    cyc(0, 5'd0, 1'b0, CNT_RSVD, 3'd4, 5'd5, 1'b1, 1'b1, "rsvd");
    cyc(0, 5'd0, 1'b0, CNT_RSVD, 3'd5, 5'd5, 1'b1, 1'b1, "rsvd");
    cyc(0, 5'd0, 1'b0, CNT_UP, 3'd6, 5'd6, 1'b0, 1'b1, "up1");
    cyc(0, 5'd5, 1'b1, CNT_UP, 3'd7, 5'd5, 1'b0, 1'b1, "load5up");
    cyc(0, 5'd0, 1'b0, CNT_HOLD, 3'd0, 5'd5, 1'b0, 1'b1, "hold5");
    cyc(0, 5'd16, 1'b1, CNT_HOLD, 3'd1, 5'd16, 1'b0, 1'b1, "load16");
    cyc(0, 5'd0, 1'b1, CNT_DOWN, 3'd2, 5'd0, 1'b1, 1'b1, "load0down");

    // Mid-run reset with counter=9 and a load/step pending
    cyc(0, 5'd9, 1'b1, CNT_HOLD, 3'd5, 5'd9, 1'b0, 1'b1, "load9");
    ld = 5'd3; ld_en = 1'b1; cs = CNT_UP; msn = 3'd6;
    #1 rst = 1'b1;
    q.push_back(mk(2, 5'b11111, 5'd0, 1'b0, 3'd0, 1'b1, 1'b0, "midreset"));
    ->async_ev;
    q.push_back(mk(0, 5'b11111, 5'd0, 1'b0, 3'd0, 1'b1, 1'b0, "inreset"));
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 5'd0, 1'b0, CNT_HOLD, 3'd3, 5'd0, 1'b0, 1'b1, "postreset");
    cyc(0, 5'd0, 1'b0, CNT_DOWN, 3'd4, 5'd0, 1'b1, 1'b1, "kb0");

    // Prescaler instance: fresh reset, then UP for 12 cycles
    rst = 1'b1;
    ld_en = 1'b0; cs = CNT_HOLD; msn = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc(1, 5'd0, 1'b0, CNT_UP, 3'(k - 1), 5'(k / 4), 1'b0, (k % 4) == 3, "div4up");
    end
    // Load on a non-tick cycle; prescaler phase must carry on undisturbed
    cyc(1, 5'd7, 1'b1, CNT_HOLD, 3'd2, 5'd7, 1'b0, 1'b0, "div4load");
    cyc(1, 5'd0, 1'b0, CNT_UP, 3'd1, 5'd7, 1'b0, 1'b0, "div4phase");
    cyc(1, 5'd0, 1'b0, CNT_UP, 3'd0, 5'd7, 1'b0, 1'b1, "div4phase");
    cyc(1, 5'd0, 1'b0, CNT_UP, 3'd3, 5'd8, 1'b0, 1'b0, "div4phase");

    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
